// File: rtl/counter_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module      : counter_cmd_driver
// Description : Accepts a counting command (direction, pulse count, gap) and
//               emits up/down strobes to an up/down counter while tracking
//               the counter's expected up- and down-count values.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_cmd_driver #(
    parameter int GAP_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [3:0]       cmd_len,
    input  logic [GAP_W-1:0] cmd_gap,
    output logic             up_down,
    output logic             down_up,
    output logic [3:0]       exp_u,
    output logic [3:0]       exp_d,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] C_LEN_ZERO_PULSES = 5'd16;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_dir;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [4:0]       r_remain;
    logic [3:0]       r_exp_u;
    logic [3:0]       r_exp_d;

    logic             w_accept;
    logic             w_last_pulse;
    logic             w_gap_zero;
    logic             w_gap_last;

    assign w_accept     = cmd_valid & (r_state == S_IDLE);
    assign w_last_pulse = (r_remain == 5'd1);
    assign w_gap_zero   = (r_gap == '0);
    assign w_gap_last   = (r_gap_cnt == GAP_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_PULSE;
                end
            end
            S_PULSE: begin
                if (w_last_pulse) begin
                    w_state_nxt = S_DONE;
                end else if (w_gap_zero) begin
                    w_state_nxt = S_PULSE;
                end else begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_last) begin
                    w_state_nxt = S_PULSE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command fields are captured only on the handshake and held for the whole command.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir     <= 1'b0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_remain  <= 5'd0;
            r_exp_u   <= 4'd0;
            r_exp_d   <= 4'd0;
        end else begin
            if (w_accept) begin
                r_dir    <= cmd_dir;
                r_gap    <= cmd_gap;
                r_remain <= (cmd_len == 4'd0) ? C_LEN_ZERO_PULSES : {1'b0, cmd_len};
            end
            if (r_state == S_PULSE) begin
                r_remain  <= r_remain - 5'd1;
                r_gap_cnt <= r_gap;
                if (r_dir) begin
                    r_exp_u <= r_exp_u + 4'd1;
                end else begin
                    r_exp_d <= r_exp_d - 4'd1;
                end
            end
            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign up_down   = (r_state == S_PULSE) &  r_dir;
    assign down_up   = (r_state == S_PULSE) & ~r_dir;
    assign exp_u     = r_exp_u;
    assign exp_d     = r_exp_d;

endmodule
`default_nettype wire

// File: tb/tb_counter_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_cmd_driver
// Description : Directed table-driven bench for counter_cmd_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_cmd_driver;

    localparam int GAP_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [3:0]       cmd_len;
    logic [GAP_W-1:0] cmd_gap;
    logic             up_down;
    logic             down_up;
    logic [3:0]       exp_u;
    logic [3:0]       exp_d;
    logic             busy;
    logic             done;

    counter_cmd_driver #(.GAP_W(GAP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .cmd_gap   (cmd_gap),
        .up_down   (up_down),
        .down_up   (down_up),
        .exp_u     (exp_u),
        .exp_d     (exp_d),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Strobes must never overlap anywhere in the run.
    always @(negedge clk) begin
        check("strobe_exclusive", {31'd0, up_down & down_up}, 32'd0);
    end

    typedef struct {
        logic             rst;
        logic             vld;
        logic             dir;
        logic [3:0]       len;
        logic [GAP_W-1:0] gap;
        logic [12:0]      exp;
    } vec_t;

    // {ready, busy, done, up, dn, exp_u, exp_d}
    function automatic logic [12:0] mk(input logic r, input logic b, input logic d,
                                       input logic u, input logic dn,
                                       input logic [3:0] eu, input logic [3:0] ed);
        return {r, b, d, u, dn, eu, ed};
    endfunction

    function automatic logic [12:0] outs();
        return {cmd_ready, busy, done, up_down, down_up, exp_u, exp_d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[17];

    int strobes;
    int busyc;
    int dones;
    int ups;
    int dns;
    int cyc;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_len = 4'd0; cmd_gap = '0;

        // up / len 3 / gap 0
        vt[0]  = '{1, 0, 0, 4'd0, 2'd0, mk(1, 0, 0, 0, 0, 4'd0, 4'd0)};
        vt[1]  = '{0, 1, 1, 4'd3, 2'd0, mk(0, 1, 0, 1, 0, 4'd0, 4'd0)};
        vt[2]  = '{0, 0, 0, 4'd0, 2'd0, mk(0, 1, 0, 1, 0, 4'd1, 4'd0)};
        vt[3]  = '{0, 0, 0, 4'd0, 2'd0, mk(0, 1, 0, 1, 0, 4'd2, 4'd0)};
        vt[4]  = '{0, 0, 0, 4'd0, 2'd0, mk(0, 1, 1, 0, 0, 4'd3, 4'd0)};
        vt[5]  = '{0, 0, 0, 4'd0, 2'd0, mk(1, 0, 0, 0, 0, 4'd3, 4'd0)};
        // reset, then down / len 1: exp_d wraps to 15
        vt[6]  = '{1, 0, 0, 4'd0, 2'd0, mk(1, 0, 0, 0, 0, 4'd0, 4'd0)};
        vt[7]  = '{0, 1, 0, 4'd1, 2'd0, mk(0, 1, 0, 0, 1, 4'd0, 4'd0)};
        vt[8]  = '{0, 0, 0, 4'd0, 2'd0, mk(0, 1, 1, 0, 0, 4'd0, 4'd15)};
        vt[9]  = '{0, 0, 0, 4'd0, 2'd0, mk(1, 0, 0, 0, 0, 4'd0, 4'd15)};
        // up / len 2 / gap 3: strobes at k+1 and k+5, done at k+6
        vt[10] = '{0, 1, 1, 4'd2, 2'd3, mk(0, 1, 0, 1, 0, 4'd0, 4'd15)};
        vt[11] = '{0, 0, 0, 4'd0, 2'd0, mk(0, 1, 0, 0, 0, 4'd1, 4'd15)};
        vt[12] = '{0, 0, 0, 4'd0, 2'd0, mk(0, 1, 0, 0, 0, 4'd1, 4'd15)};
        vt[13] = '{0, 0, 0, 4'd0, 2'd0, mk(0, 1, 0, 0, 0, 4'd1, 4'd15)};
        vt[14] = '{0, 0, 0, 4'd0, 2'd0, mk(0, 1, 0, 1, 0, 4'd1, 4'd15)};
        vt[15] = '{0, 0, 0, 4'd0, 2'd0, mk(0, 1, 1, 0, 0, 4'd2, 4'd15)};
        vt[16] = '{0, 0, 0, 4'd0, 2'd0, mk(1, 0, 0, 0, 0, 4'd2, 4'd15)};

        for (int i = 0; i < 17; i++) begin
            reset     = vt[i].rst;
            cmd_valid = vt[i].vld;
            cmd_dir   = vt[i].dir;
            cmd_len   = vt[i].len;
            cmd_gap   = vt[i].gap;
            step();
            check($sformatf("vec%0d", i), {19'd0, outs()}, {19'd0, vt[i].exp});
        end

        // up / len 0 means 16 pulses, exp_u wraps to 0, 17 busy cycles
        reset = 1'b1; cmd_valid = 1'b0;
        step();
        reset = 1'b0; cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_len = 4'd0; cmd_gap = '0;
        step();
        cmd_valid = 1'b0;
        strobes = 0; busyc = 0; dones = 0;
        for (int c = 0; c < 40 && busy; c++) begin
            strobes += int'(up_down);
            dones   += int'(done);
            busyc++;
            step();
        end
        check("len16_idle",    {31'd0, busy}, 32'd0);
        check("len16_strobes", strobes, 16);
        check("len16_busy",    busyc, 17);
        check("len16_done",    dones, 1);
        check("len16_exp_u",   {28'd0, exp_u}, 32'd0);

        // up / len 5 aborted by reset after the second strobe
        reset = 1'b1;
        step();
        reset = 1'b0; cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_len = 4'd5; cmd_gap = '0;
        step();
        cmd_valid = 1'b0;
        check("abort_strobe1", {31'd0, up_down}, 32'd1);
        step();
        check("abort_strobe2", {31'd0, up_down}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_state", {19'd0, outs()}, {19'd0, mk(1, 0, 0, 0, 0, 4'd0, 4'd0)});
        strobes = 0; dones = 0;
        for (int c = 0; c < 10; c++) begin
            strobes += int'(up_down | down_up);
            dones   += int'(done);
            step();
        end
        check("abort_no_strobe", strobes, 0);
        check("abort_no_done",   dones, 0);

        // valid held high with changing fields while busy: ignored
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_len = 4'd2; cmd_gap = 2'd1;
        step();
        ups = 0; dns = 0; cyc = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) break;
            ups += int'(up_down);
            dns += int'(down_up);
            cyc++;
            cmd_dir = 1'($urandom);
            cmd_len = 4'($urandom);
            cmd_gap = GAP_W'($urandom);
            step();
        end
        check("hold_done_seen", {31'd0, done}, 32'd1);
        check("hold_ups",       ups, 2);
        check("hold_dns",       dns, 0);
        check("hold_cycles",    cyc, 3);
        check("hold_exp_u",     {28'd0, exp_u}, 32'd2);
        cmd_dir = 1'b0; cmd_len = 4'd1; cmd_gap = '0;
        step();
        check("next_idle",   {19'd0, outs()}, {19'd0, mk(1, 0, 0, 0, 0, 4'd2, 4'd0)});
        step();
        cmd_valid = 1'b0;
        check("next_pulse",  {19'd0, outs()}, {19'd0, mk(0, 1, 0, 0, 1, 4'd2, 4'd0)});
        step();
        check("next_done",   {19'd0, outs()}, {19'd0, mk(0, 1, 1, 0, 0, 4'd2, 4'd15)});
        step();
        check("next_ready",  {19'd0, outs()}, {19'd0, mk(1, 0, 0, 0, 0, 4'd2, 4'd15)});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_cmd_driver.md
COUNTER_CMD_DRIVER -- requirements
Module: counter_cmd_driver

Interface
REQ-001 Parameter GAP_W, default 2, sets the width of the inter-pulse gap field.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  driver can accept a command.
REQ-006 cmd_dir  input  1  1 = count up, 0 = count down.
REQ-007 cmd_len  input  4  number of pulses; 0 means 16.
REQ-008 cmd_gap  input  GAP_W  idle cycles between consecutive pulses.
REQ-009 up_down  output  1  up-increment strobe to the up/down counter.
REQ-010 down_up  output  1  down-decrement strobe to the up/down counter.
REQ-011 exp_u  output  4  expected up-count value of the counter.
REQ-012 exp_d  output  4  expected down-count value of the counter.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 done  output  1  one-cycle command-complete pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, PULSE, GAP and DONE, all registered.
REQ-016 cmd_ready SHALL be 1 only in IDLE and 0 in every other state.
REQ-017 A handshake (cmd_valid & cmd_ready at a rising edge) SHALL capture cmd_dir, cmd_len and cmd_gap, and SHALL move the FSM to PULSE.
REQ-018 Command fields SHALL be sampled only at the handshake; changes while busy SHALL have no effect.
REQ-019 cmd_valid while busy SHALL be ignored, with no queueing.
REQ-020 The remaining-pulse counter SHALL be 5 bits wide; it loads cmd_len, or 16 when cmd_len = 0.
REQ-021 In PULSE, up_down SHALL be 1 if dir = 1, otherwise down_up SHALL be 1, for exactly that one cycle.
REQ-022 up_down and down_up SHALL never be high in the same cycle, and both SHALL be 0 outside PULSE.
REQ-023 At the rising edge that ends a PULSE cycle, exp_u SHALL increment (dir = 1) or exp_d SHALL decrement (dir = 0); the remaining count SHALL decrement.
REQ-024 exp_u SHALL wrap modulo 16 (15 -> 0), and exp_d SHALL wrap modulo 16 (0 -> 15).
REQ-025 Transition out of PULSE:
  - to DONE if the remaining count reaches 0;
  - otherwise to PULSE if gap = 0;
  - otherwise to GAP.
REQ-026 GAP SHALL last exactly gap cycles, then go to PULSE, with both strobes held 0.
REQ-027 DONE SHALL last one cycle with done = 1 and busy = 1, then go to IDLE.
REQ-028 Latency: for a handshake at edge k, the first strobe SHALL be high in cycle k+1; the command SHALL occupy L + (L-1)*G + 1 cycles (L = pulses, G = gap) before returning to IDLE.
REQ-029 exp_u and exp_d SHALL persist across commands and change only on strobes or reset.

Reset
REQ-030 While reset = 1 at a rising edge, the block SHALL go to IDLE and clear exp_u, exp_d and the internal counters to 0.
REQ-031 After that edge, up_down, down_up, done and busy SHALL be 0 and cmd_ready SHALL be 1.
REQ-032 Reset SHALL take priority over any handshake in the same cycle.
REQ-033 Reset during PULSE or GAP SHALL abort the command with no further strobes and no done pulse.

Verification
REQ-034 Reset, then up/len 3/gap 0 -> up_down high for 3 consecutive cycles from k+1; exp_u = 3; done pulses one cycle later; cmd_ready = 1 the cycle after that.
REQ-035 Reset, then down/len 1 -> down_up high for one cycle; exp_d = 15 (wrap); exp_u remains 0.
REQ-036 Reset, then up/len 0/gap 0 -> 16 strobes; exp_u = 0 (wrap); 17 busy cycles.
REQ-037 up/len 2/gap 3 -> up_down high in cycles k+1 and k+5; done in cycle k+6; exp_u increments by 2.
REQ-038 up/len 5, reset asserted after the 2nd strobe -> no further strobes; exp_u = 0; no done; cmd_ready = 1 on the next cycle.
REQ-039 cmd_valid held high with changing fields during a command -> ignored; the next command is accepted at the first edge in IDLE after done; up_down and down_up are never high together anywhere in the test.
